// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO controller serving instruction fetch and the load/store buffer.
// One transaction at a time, LSB has priority; words are assembled little-endian.
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h00030000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        IF_enable,
    input  logic [31:0] IF_addr,
    output logic        IF_data_valid,
    output logic [31:0] IF_data,
    input  logic        LSB_enable,
    input  logic        LSB_is_write,
    input  logic [31:0] LSB_addr,
    input  logic [2:0]  LSB_data_len,
    input  logic [31:0] LSB_write_data,
    output logic        LSB_data_valid,
    output logic [31:0] LSB_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_lsb_q, owner_lsb_d;
    logic        io_q, io_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_data_q, if_data_d;
    logic        lsb_valid_q, lsb_valid_d;
    logic [31:0] lsb_data_q, lsb_data_d;

    logic [31:0] rd_word;
    logic        lsb_io;
    logic        stall;

    always_comb begin
        state_d     = state_q;
        owner_lsb_d = owner_lsb_q;
        io_d        = io_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        asm_d       = asm_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        if_valid_d  = 1'b0;
        if_data_d   = if_data_q;
        lsb_valid_d = 1'b0;
        lsb_data_d  = lsb_data_q;

        rd_word = asm_q | ({24'h0, mem_din} << {cnt_q, 3'b000});
        lsb_io  = (LSB_addr >= IO_BASE);
        stall   = io_q && io_buffer_full;

        case (state_q)
            IDLE: begin
                if (LSB_enable) begin
                    owner_lsb_d = 1'b1;
                    addr_d      = LSB_addr;
                    wdata_d     = LSB_write_data;
                    len_d       = LSB_data_len;
                    io_d        = lsb_io;
                    cnt_d       = '0;
                    asm_d       = '0;
                    mem_a_d     = LSB_addr;
                    if (LSB_is_write) begin
                        state_d    = WRITE;
                        mem_dout_d = LSB_write_data[7:0];
                        // cnt counts bytes already issued; a full I/O buffer delays byte 0 too
                        if (!(lsb_io && io_buffer_full)) begin
                            mem_wr_d = 1'b1;
                            cnt_d    = 3'd1;
                        end
                    end else begin
                        state_d = READ;
                    end
                end else if (IF_enable && !clear) begin
                    owner_lsb_d = 1'b0;
                    addr_d      = IF_addr;
                    len_d       = 3'd4;
                    io_d        = 1'b0;
                    cnt_d       = '0;
                    asm_d       = '0;
                    mem_a_d     = IF_addr;
                    state_d     = READ;
                end
            end
            READ: begin
                if (clear && !owner_lsb_q) begin
                    state_d = IDLE;
                end else if (cnt_q == len_q - 3'd1) begin
                    asm_d   = rd_word;
                    state_d = DONE;
                    if (owner_lsb_q) begin
                        lsb_valid_d = 1'b1;
                        lsb_data_d  = rd_word;
                    end else begin
                        if_valid_d = 1'b1;
                        if_data_d  = rd_word;
                    end
                end else begin
                    asm_d   = rd_word;
                    cnt_d   = cnt_q + 3'd1;
                    mem_a_d = addr_q + {29'b0, cnt_q} + 32'd1;
                end
            end
            WRITE: begin
                if (cnt_q == len_q) begin
                    state_d     = DONE;
                    lsb_valid_d = 1'b1;
                end else if (!stall) begin
                    mem_a_d    = addr_q + {29'b0, cnt_q};
                    mem_dout_d = 8'(wdata_q >> {cnt_q, 3'b000});
                    mem_wr_d   = 1'b1;
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_lsb_q <= 1'b0;
            io_q        <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            if_valid_q  <= 1'b0;
            if_data_q   <= '0;
            lsb_valid_q <= 1'b0;
            lsb_data_q  <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_lsb_q <= owner_lsb_d;
            io_q        <= io_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
            lsb_valid_q <= lsb_valid_d;
            lsb_data_q  <= lsb_data_d;
        end
    end

    // A flush in the DONE cycle must still suppress the already-registered fetch pulse
    assign IF_data_valid  = if_valid_q & ~clear;
    assign IF_data        = if_data_q;
    assign LSB_data_valid = lsb_valid_q;
    assign LSB_data       = lsb_data_q;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte-addressed RAM model with combinational read
// and a log of every byte the controller writes.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        IF_enable, IF_data_valid;
    logic [31:0] IF_addr, IF_data;
    logic        LSB_enable, LSB_is_write, LSB_data_valid;
    logic [31:0] LSB_addr, LSB_write_data, LSB_data;
    logic [2:0]  LSB_data_len;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] if_q[$];
    logic [31:0] lsb_q[$];
    logic [39:0] wr_exp[$];
    logic [39:0] wr_log[$];
    logic [7:0]  ram [0:4095];

    mem_ctrl #(.IO_BASE(32'h00030000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .IF_enable(IF_enable), .IF_addr(IF_addr),
        .IF_data_valid(IF_data_valid), .IF_data(IF_data),
        .LSB_enable(LSB_enable), .LSB_is_write(LSB_is_write), .LSB_addr(LSB_addr),
        .LSB_data_len(LSB_data_len), .LSB_write_data(LSB_write_data),
        .LSB_data_valid(LSB_data_valid), .LSB_data(LSB_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) begin
        if (mem_wr === 1'b1) wr_log.push_back({mem_a, mem_dout});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit lsb, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            if ((lsb ? LSB_data_valid : IF_data_valid) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic lsb_req(input logic w, input logic [31:0] a, input logic [2:0] n,
                           input logic [31:0] d);
        LSB_enable     = 1'b1;
        LSB_is_write   = w;
        LSB_addr       = a;
        LSB_data_len   = n;
        LSB_write_data = d;
    endtask

    task automatic test_reset;
        #3;
        n_checks++;
        if ({IF_data_valid, LSB_data_valid, mem_wr} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b, want 000", {IF_data_valid, LSB_data_valid, mem_wr});
        end
        n_checks++;
        if (IF_data !== 32'h0 || LSB_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h, want 0/0", IF_data, LSB_data);
        end
        n_checks++;
        if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_fail++; $display("FAIL reset_mem: got %h/%h, want 0/0", mem_a, mem_dout);
        end
        tick; tick;
        rst = 1'b1;
        tick;
        n_checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %h/%b, want 0/0", mem_a, mem_wr);
        end
    endtask

    task automatic test_if_fetch;
        logic [31:0] exp;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        if_q.push_back(32'h00000513);
        IF_addr = 32'h100; IF_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            n_checks++;
            if (mem_a !== 32'h100 + k || mem_wr !== 1'b0 || IF_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL fetch_addr%0d: got %h wr=%b v=%b, want %h wr=0 v=0", k, mem_a, mem_wr, IF_data_valid, 32'h100 + k);
            end
        end
        tick;
        exp = if_q.pop_front();
        n_checks++;
        if (IF_data_valid !== 1'b1 || IF_data !== exp) begin
            n_fail++; $display("FAIL fetch_data: got v=%b %h, want v=1 %h", IF_data_valid, IF_data, exp);
        end
        IF_enable = 1'b0;
        tick;
        n_checks++;
        if (IF_data_valid !== 1'b0 || IF_data !== exp) begin
            n_fail++; $display("FAIL fetch_pulse_hold: got v=%b %h, want v=0 %h", IF_data_valid, IF_data, exp);
        end
    endtask

    task automatic test_loads;
        logic [31:0] la[4] = '{32'h210, 32'h213, 32'h200, 32'hFFFFFFFE};
        logic [2:0]  ln[4] = '{3'd4, 3'd1, 3'd2, 3'd4};
        logic [31:0] le[4] = '{32'h84332211, 32'h00000084, 32'h0000FFFE, 32'hDDCCBBAA};
        logic [31:0] exp;
        int cyc;
        ram[12'h200] = 8'hFE; ram[12'h201] = 8'hFF;
        ram[12'h210] = 8'h11; ram[12'h211] = 8'h22; ram[12'h212] = 8'h33; ram[12'h213] = 8'h84;
        ram[12'hFFE] = 8'hAA; ram[12'hFFF] = 8'hBB; ram[12'h000] = 8'hCC; ram[12'h001] = 8'hDD;
        for (int i = 0; i < 4; i++) begin
            lsb_q.push_back(le[i]);
            lsb_req(1'b0, la[i], ln[i], 32'hFFFFFFFF);
            wait_valid(1'b1, cyc);
            LSB_enable = 1'b0;
            exp = lsb_q.pop_front();
            n_checks++;
            if (cyc != int'(ln[i]) + 1) begin
                n_fail++; $display("FAIL load%0d_latency: got %0d, want %0d", i, cyc, int'(ln[i]) + 1);
            end
            n_checks++;
            if (LSB_data !== exp || IF_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL load%0d_data: got %h ifv=%b, want %h ifv=0", i, LSB_data, IF_data_valid, exp);
            end
            tick;
            n_checks++;
            if (LSB_data_valid !== 1'b0 || LSB_data !== exp) begin
                n_fail++; $display("FAIL load%0d_pulse: got v=%b %h, want v=0 %h", i, LSB_data_valid, LSB_data, exp);
            end
        end
    endtask

    task automatic test_store;
        logic [31:0] wd = 32'hDEADBEEF;
        int base, cyc;
        base = wr_log.size();
        for (int k = 0; k < 4; k++) wr_exp.push_back({32'h300 + k, wd[8*k +: 8]});
        lsb_req(1'b1, 32'h300, 3'd4, wd);
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        n_checks++;
        if (cyc != 5) begin
            n_fail++; $display("FAIL sw_latency: got %0d, want 5", cyc);
        end
        n_checks++;
        if (wr_log.size() - base != 4) begin
            n_fail++; $display("FAIL sw_count: got %0d, want 4", wr_log.size() - base);
        end
        for (int k = 0; k < 4 && base + k < wr_log.size(); k++) begin
            logic [39:0] e;
            e = wr_exp.pop_front();
            n_checks++;
            if (wr_log[base + k] !== e) begin
                n_fail++; $display("FAIL sw_byte%0d: got %h, want %h", k, wr_log[base + k], e);
            end
        end
        wr_exp.delete();
        tick;
    endtask

    task automatic test_arbitration;
        logic [31:0] exp;
        int cyc;
        ram[12'h120] = 8'h67; ram[12'h121] = 8'h45; ram[12'h122] = 8'h23; ram[12'h123] = 8'h01;
        ram[12'h220] = 8'h5A;
        if_q.push_back(32'h01234567);
        lsb_q.push_back(32'h0000005A);
        IF_addr = 32'h120; IF_enable = 1'b1;
        lsb_req(1'b0, 32'h220, 3'd1, 32'h0);
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        exp = lsb_q.pop_front();
        n_checks++;
        if (cyc != 2 || IF_data_valid !== 1'b0 || LSB_data !== exp) begin
            n_fail++; $display("FAIL arb_lsb_first: got cyc=%0d ifv=%b %h, want cyc=2 ifv=0 %h", cyc, IF_data_valid, LSB_data, exp);
        end
        tick;
        n_checks++;
        if (mem_a !== 32'h220) begin
            n_fail++; $display("FAIL arb_no_accept_in_done: got %h, want 00000220", mem_a);
        end
        tick;
        n_checks++;
        if (mem_a !== 32'h120) begin
            n_fail++; $display("FAIL arb_if_accept: got %h, want 00000120", mem_a);
        end
        wait_valid(1'b0, cyc);
        IF_enable = 1'b0;
        exp = if_q.pop_front();
        n_checks++;
        if (cyc != 4 || IF_data !== exp) begin
            n_fail++; $display("FAIL arb_if_data: got cyc=%0d %h, want cyc=4 %h", cyc, IF_data, exp);
        end
        tick;
    endtask

    task automatic test_clear;
        int pulses, cyc;
        logic [31:0] exp;
        IF_addr = 32'h140; IF_enable = 1'b1;
        tick; tick; tick;
        n_checks++;
        if (mem_a !== 32'h142) begin
            n_fail++; $display("FAIL clr_byte2: got %h, want 00000142", mem_a);
        end
        clear = 1'b1; IF_enable = 1'b0;
        tick;
        clear = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (IF_data_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || mem_a !== 32'h142) begin
            n_fail++; $display("FAIL clr_if_abort: got pulses=%0d a=%h, want 0 00000142", pulses, mem_a);
        end
        IF_addr = 32'h120; IF_enable = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        n_checks++;
        if (IF_data_valid !== 1'b1) begin
            n_fail++; $display("FAIL clr_done_pre: got %b, want 1", IF_data_valid);
        end
        clear = 1'b1; IF_enable = 1'b0;
        #1;
        n_checks++;
        if (IF_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_done_gate: got %b, want 0", IF_data_valid);
        end
        tick;
        IF_addr = 32'h100; IF_enable = 1'b1;
        tick;
        n_checks++;
        if (mem_a !== 32'h123 || IF_data_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_idle_block: got %h v=%b, want 00000123 v=0", mem_a, IF_data_valid);
        end
        clear = 1'b0;
        if_q.push_back(32'h00000513);
        tick;
        n_checks++;
        if (mem_a !== 32'h100) begin
            n_fail++; $display("FAIL clr_idle_release: got %h, want 00000100", mem_a);
        end
        wait_valid(1'b0, cyc);
        IF_enable = 1'b0;
        exp = if_q.pop_front();
        n_checks++;
        if (cyc != 4 || IF_data !== exp) begin
            n_fail++; $display("FAIL clr_refetch: got cyc=%0d %h, want cyc=4 %h", cyc, IF_data, exp);
        end
        tick;
        cyc = wr_log.size();
        wr_exp.push_back({32'h310, 8'h77});
        lsb_req(1'b1, 32'h310, 3'd1, 32'h77);
        tick;
        clear = 1'b1;
        pulses = cyc;
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0; clear = 1'b0;
        exp = {24'h0, 8'h00};
        n_checks++;
        if (cyc != 1 || wr_log.size() != pulses + 1) begin
            n_fail++; $display("FAIL clr_lsb_complete: got cyc=%0d writes=%0d, want cyc=1 writes=1", cyc, wr_log.size() - pulses);
        end else begin
            logic [39:0] e;
            e = wr_exp.pop_front();
            n_checks++;
            if (wr_log[pulses] !== e) begin
                n_fail++; $display("FAIL clr_lsb_byte: got %h, want %h", wr_log[pulses], e);
            end
        end
        wr_exp.delete();
        tick;
    endtask

    task automatic test_io_stall;
        int base, cyc;
        logic [39:0] e;
        io_buffer_full = 1'b1;
        base = wr_log.size();
        wr_exp.push_back({32'h0002FFFF, 8'h3C});
        lsb_req(1'b1, 32'h0002FFFF, 3'd1, 32'h3C);
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        e = wr_exp.pop_front();
        n_checks++;
        if (cyc != 2 || wr_log.size() != base + 1 || wr_log[base] !== e) begin
            n_fail++; $display("FAIL io_below_base: got cyc=%0d writes=%0d, want cyc=2 writes=1 %h", cyc, wr_log.size() - base, e);
        end
        tick;
        base = wr_log.size();
        lsb_req(1'b1, 32'h00030000, 3'd1, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (mem_wr !== 1'b0 || LSB_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL io_stall%0d: got wr=%b v=%b, want 0 0", i, mem_wr, LSB_data_valid);
            end
        end
        io_buffer_full = 1'b0;
        tick;
        n_checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h00030000 || mem_dout !== 8'hA5) begin
            n_fail++; $display("FAIL io_write: got wr=%b %h %h, want 1 00030000 a5", mem_wr, mem_a, mem_dout);
        end
        tick;
        LSB_enable = 1'b0;
        n_checks++;
        if (LSB_data_valid !== 1'b1 || wr_log.size() != base + 1) begin
            n_fail++; $display("FAIL io_done: got v=%b writes=%0d, want 1 1", LSB_data_valid, wr_log.size() - base);
        end
        tick;
        base = wr_log.size();
        wr_exp.push_back({32'h00030010, 8'h34});
        wr_exp.push_back({32'h00030011, 8'h12});
        lsb_req(1'b1, 32'h00030010, 3'd2, 32'h1234);
        tick;
        io_buffer_full = 1'b1;
        tick;
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL io_mid_stall: got %b, want 0", mem_wr);
        end
        io_buffer_full = 1'b0;
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        n_checks++;
        if (cyc != 2 || wr_log.size() != base + 2) begin
            n_fail++; $display("FAIL io_mid_done: got cyc=%0d writes=%0d, want 2 2", cyc, wr_log.size() - base);
        end
        for (int k = 0; k < 2 && base + k < wr_log.size(); k++) begin
            e = wr_exp.pop_front();
            n_checks++;
            if (wr_log[base + k] !== e) begin
                n_fail++; $display("FAIL io_mid_byte%0d: got %h, want %h", k, wr_log[base + k], e);
            end
        end
        wr_exp.delete();
        tick;
    endtask

    task automatic test_rdy;
        int base, cyc;
        logic [31:0] exp;
        logic [39:0] e;
        lsb_q.push_back(32'h00000513);
        lsb_req(1'b0, 32'h100, 3'd4, 32'h0);
        tick; tick;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++;
            if (mem_a !== 32'h101 || LSB_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL rdy_hold%0d: got %h v=%b, want 00000101 v=0", i, mem_a, LSB_data_valid);
            end
        end
        rdy = 1'b1;
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        exp = lsb_q.pop_front();
        n_checks++;
        if (cyc != 3 || LSB_data !== exp) begin
            n_fail++; $display("FAIL rdy_read: got cyc=%0d %h, want cyc=3 %h", cyc, LSB_data, exp);
        end
        tick;
        base = wr_log.size();
        wr_exp.push_back({32'h330, 8'h34});
        wr_exp.push_back({32'h331, 8'h12});
        lsb_req(1'b1, 32'h330, 3'd2, 32'h1234);
        tick;
        rdy = 1'b0;
        #1;
        n_checks++;
        if (mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL rdy_wr_gate: got %b, want 0", mem_wr);
        end
        tick; tick;
        rdy = 1'b1;
        wait_valid(1'b1, cyc);
        LSB_enable = 1'b0;
        n_checks++;
        if (cyc != 2 || wr_log.size() != base + 2) begin
            n_fail++; $display("FAIL rdy_write: got cyc=%0d writes=%0d, want 2 2", cyc, wr_log.size() - base);
        end
        for (int k = 0; k < 2 && base + k < wr_log.size(); k++) begin
            e = wr_exp.pop_front();
            n_checks++;
            if (wr_log[base + k] !== e) begin
                n_fail++; $display("FAIL rdy_byte%0d: got %h, want %h", k, wr_log[base + k], e);
            end
        end
        wr_exp.delete();
        tick;
    endtask

    task automatic test_reset_mid;
        int pulses;
        lsb_req(1'b0, 32'h210, 3'd4, 32'h0);
        tick; tick;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({IF_data_valid, LSB_data_valid, mem_wr} !== 3'b000 || IF_data !== 32'h0 ||
            LSB_data !== 32'h0 || mem_a !== 32'h0 || mem_dout !== 8'h0) begin
            n_fail++; $display("FAIL reset_mid: got a=%h if=%h lsb=%h, want all 0", mem_a, IF_data, LSB_data);
        end
        tick;
        LSB_enable = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (LSB_data_valid === 1'b1 || IF_data_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 0 || mem_a !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got pulses=%0d a=%h, want 0 0", pulses, mem_a);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        rst = 1'b0; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
        IF_enable = 1'b0; IF_addr = '0;
        LSB_enable = 1'b0; LSB_is_write = 1'b0; LSB_addr = '0;
        LSB_data_len = '0; LSB_write_data = '0;
        test_reset;
        test_if_fetch;
        test_loads;
        test_store;
        test_arbitration;
        test_clear;
        test_io_stall;
        test_rdy;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the 8-bit unified RAM/IO port and two 32-bit requesters: instruction fetch (IF) and the load/store buffer (LSB).
- Accepts one transaction at a time and arbitrates LSB over IF.
- Serialises a 1/2/4-byte access into byte cycles and returns the assembled little-endian word with a one-cycle valid pulse.
- Its LSB-side outputs are the data_valid/data inputs consumed by the load/store buffer.

Parameters:
- IO_BASE, 32'h00030000, addresses >= IO_BASE are I/O-mapped; stores there obey io_buffer_full.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; low freezes all state.
- clear  in  1  pipeline flush (mispredict).
- IF_enable  in  1  fetch request, level, held until IF_data_valid.
- IF_addr  in  32  fetch address, 4 bytes always.
- IF_data_valid  out  1  one-cycle pulse, IF_data valid.
- IF_data  out  32  fetched word.
- LSB_enable  in  1  LSB request, level.
- LSB_is_write  in  1  1 = store, 0 = load.
- LSB_addr  in  32  byte address.
- LSB_data_len  in  3  byte count; legal values are 1, 2 and 4.
- LSB_write_data  in  32  store data; low LSB_data_len bytes are used.
- LSB_data_valid  out  1  one-cycle pulse: load data ready or store done.
- LSB_data  out  32  load data, zero-extended raw bytes.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All outputs 0: both valids, IF_data, LSB_data, mem_a, mem_dout, mem_wr.
  - Byte counter 0, assembly register 0.
- States are IDLE, READ, WRITE, DONE. The owner bit (IF/LSB) and length N (IF: 4) are latched on accept.
- IDLE:
  - If LSB_enable=1, accept LSB and go to READ or WRITE according to LSB_is_write.
  - Otherwise, if IF_enable=1 and clear=0, accept IF and go to READ.
  - LSB wins a simultaneous request; IF stays pending.
  - Address, data and length are latched at the accept edge; requester inputs are ignored afterwards.
- READ, accept at edge 0:
  - mem_a = addr+k is driven after edge k, for k = 0..N-1. mem_wr=0.
  - The byte for address addr+k is captured from mem_din at edge k+1 into bits [8k+7:8k].
  - After edge N the last byte is in, and the state goes to DONE.
- WRITE, accept at edge 0:
  - After edge k (k = 0..N-1): mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - After edge N: mem_wr=0, state=DONE.
  - I/O stall: if addr >= IO_BASE and io_buffer_full=1 at a byte edge, the byte is not advanced and mem_wr=0 for that cycle. The same byte is retried on the next edge.
- DONE:
  - Lasts exactly one cycle, with the owner's *_data_valid=1.
  - Data bits above 8N are 0.
  - Next edge returns to IDLE. No request is accepted in DONE, so a requester's stale enable is never re-sampled.
- Valid pulses are exactly one cycle wide. IF_data and LSB_data hold their last value after the pulse.
- Address arithmetic is 32-bit wrap-around. Byte counter width is 3 bits.
- clear=1:
  - If the owner is IF (READ or DONE): abort to IDLE; IF_data_valid is forced 0 that cycle and no IF_data_valid is emitted.
  - LSB transactions are never aborted, because they are committed stores/loads. They complete normally.
  - In IDLE, clear blocks IF acceptance for that cycle only.
- rdy=0:
  - state, counters and registered outputs hold.
  - mem_wr is forced 0 combinationally, so no byte is written twice.
  - Valid pulses are not re-emitted on resume.
- Reset mid-transaction returns immediately to IDLE with all outputs 0. No partial valid is produced.
- Latency from request at IDLE edge to valid pulse:
  - Read of N bytes: valid after edge N+1.
  - Write of N bytes: valid after edge N+1, plus stall cycles.

Test Plan:
- IF fetch: RAM[0x100..0x103] = 13,05,00,00; IF_enable, IF_addr=0x100 -> mem_a 0x100..0x103 on four consecutive cycles; IF_data_valid pulse after edge 5 with IF_data=0x00000513.
- LH: LSB_enable, LSB_addr=0x200, data_len=2, RAM = 0xFE,0xFF -> LSB_data=0x0000FFFE after edge 3, single pulse.
- SW: LSB_addr=0x300, write_data=0xDEADBEEF, len 4 -> mem_wr=1 on 4 cycles writing EF, BE, AD, DE at 0x300..0x303; LSB_data_valid after edge 5.
- Arbitration: IF_enable and LSB_enable rise together -> LSB served first; IF accepted in the IDLE cycle after the LSB pulse; no request accepted in DONE.
- clear during IF byte 2 -> state IDLE next edge, no IF_data_valid. clear during LSB SB -> store completes, LSB_data_valid pulses.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, then one write, valid one cycle later. rdy=0 mid-read -> mem_a holds, result still correct.
